// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment presenter for the stopwatch BCD counters.
// The displayed value only changes at frame boundaries; a snapshot register supports freeze/lap.
//
// state  | meaning
// S_IDLE | no snapshot request outstanding
// S_PEND | request seen, capture at next frame boundary
module stopwatch_display_scan #(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DP_MASK,
  input  logic        FREEZE,
  input  logic        SNAP_REQ,
  input  logic        BLANK_LZ,
  output logic        SNAP_ACK,
  output logic        FRAME,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } snap_state_t;

  snap_state_t r_state;
  snap_state_t w_state_nxt;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_index;
  logic [15:0]   r_disp;
  logic [15:0]   r_snap;
  logic          r_frame;
  logic          r_ack;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_boundary;
  logic          w_capture;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg_dec;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_index == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc <= '0;
      r_index <= 2'd0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_index <= r_index + 2'd1;
    end
  end

  // Snapshot handshake: a request in the boundary cycle itself is captured immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (SNAP_REQ) begin
          if (w_boundary) w_capture   = 1'b1;
          else            w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_boundary) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // DISP samples the old SNAP when both load together, so a new lap shows one frame later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_disp  <= 16'h0000;
      r_snap  <= 16'h0000;
      r_frame <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      r_ack   <= w_capture;
      if (w_boundary) r_disp <= FREEZE ? r_snap : DIGITS_IN;
      if (w_capture)  r_snap <= DIGITS_IN;
    end
  end

  always_comb begin
    w_digit = r_disp[3:0];
    case (r_index)
      2'd0: w_digit = r_disp[3:0];
      2'd1: w_digit = r_disp[7:4];
      2'd2: w_digit = r_disp[11:8];
      2'd3: w_digit = r_disp[15:12];
      default: w_digit = r_disp[3:0];
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
    if (BLANK_EN && BLANK_LZ) begin
      if (r_index == 2'd3) w_blank = (r_disp[15:12] == 4'd0);
      if (r_index == 2'd2) w_blank = (r_disp[15:8] == 8'd0);
    end
  end

  assign w_seg_dec = seg_decode(w_digit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_index);
      r_seg <= w_blank ? 7'b1111111 : w_seg_dec;
      r_dp  <= ~DP_MASK[r_index];
    end
  end

  assign SNAP_ACK = r_ack;
  assign FRAME    = r_frame;
  assign AN       = r_an;
  assign SEG      = r_seg;
  assign DP       = r_dp;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan with CLK_DIV=4; per-slot expectations are
// queued per frame and popped as each digit slot is displayed.
module tb_stopwatch_display_scan;

  logic        CLK;
  logic        RST;
  logic [15:0] DIGITS_IN;
  logic [3:0]  DP_MASK;
  logic        FREEZE;
  logic        SNAP_REQ;
  logic        BLANK_LZ;
  logic        SNAP_ACK;
  logic        FRAME;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  stopwatch_display_scan #(.CLK_DIV(4), .BLANK_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .DIGITS_IN(DIGITS_IN), .DP_MASK(DP_MASK),
    .FREEZE(FREEZE), .SNAP_REQ(SNAP_REQ), .BLANK_LZ(BLANK_LZ),
    .SNAP_ACK(SNAP_ACK), .FRAME(FRAME), .AN(AN), .SEG(SEG), .DP(DP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [15:0] disp, input logic [3:0] mask, input logic blank);
    slot_t e;
    logic [3:0] d;
    for (int j = 0; j < 4; j++) begin
      d = disp[4*j +: 4];
      e.an  = 4'b1111;
      e.an[j] = 1'b0;
      e.seg = exp_seg(d);
      if (blank && j == 3 && disp[15:12] == 4'd0) e.seg = 7'b1111111;
      if (blank && j == 2 && disp[15:8] == 8'd0)  e.seg = 7'b1111111;
      e.dp  = ~mask[j];
      q.push_back(e);
    end
  endtask

  // Entered at the negedge where FRAME is high; leaves at the next FRAME negedge.
  task automatic check_frame(input string tag);
    slot_t e;
    for (int j = 0; j < 4; j++) begin
      repeat (2) @(negedge CLK);
      if (q.size() == 0) begin
        chk({tag, "_queue_empty"}, 16'd0, 16'd1);
      end else begin
        e = q.pop_front();
        chk({tag, "_an"},  {12'd0, AN},  {12'd0, e.an});
        chk({tag, "_seg"}, {9'd0, SEG},  {9'd0, e.seg});
        chk({tag, "_dp"},  {15'd0, DP},  {15'd0, e.dp});
        chk({tag, "_frame_low"}, {15'd0, FRAME}, 16'd0);
        chk({tag, "_ack_low"}, {15'd0, SNAP_ACK}, 16'd0);
      end
      repeat (2) @(negedge CLK);
    end
    chk({tag, "_frame_period"}, {15'd0, FRAME}, 16'd1);
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (FRAME !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_frame_seen"}, {15'd0, FRAME}, 16'd1);
  endtask

  initial begin
    int acks;
    RST = 1'b0; DIGITS_IN = 16'h1234; DP_MASK = 4'b0000;
    FREEZE = 1'b0; SNAP_REQ = 1'b0; BLANK_LZ = 1'b0;

    // Reset values, then digit 0 of cleared DISP before first tick.
    @(negedge CLK);
    chk("rst_an",  {12'd0, AN},  16'h000F);
    chk("rst_seg", {9'd0, SEG},  16'h007F);
    chk("rst_dp",  {15'd0, DP},  16'd1);
    chk("rst_frame", {15'd0, FRAME}, 16'd0);
    chk("rst_ack", {15'd0, SNAP_ACK}, 16'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_an",  {12'd0, AN}, 16'h000E);
    chk("post_rst_seg", {9'd0, SEG}, 16'h0040);

    // Scan of live 1234.
    wait_frame("scan");
    push_frame(16'h1234, 4'b0000, 1'b0);
    check_frame("scan1234");

    // Tear-free: new live value waits for the next boundary.
    DIGITS_IN = 16'h5678;
    push_frame(16'h1234, 4'b0000, 1'b0);
    check_frame("tear_old");
    push_frame(16'h5678, 4'b0000, 1'b0);
    check_frame("tear_new");

    // Two requests within one frame merge into a single ACK at FRAME.
    DIGITS_IN = 16'h0942;
    SNAP_REQ = 1'b1;
    acks = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      acks += int'(SNAP_ACK);
      SNAP_REQ = (i == 5);
    end
    chk("snap_ack_at_frame", {14'd0, SNAP_ACK, FRAME}, 16'h0003);
    chk("snap_ack_count", 16'(acks), 16'd1);

    // Freeze: display holds the snapshot while live digits move on.
    FREEZE = 1'b1;
    DIGITS_IN = 16'h0959;
    push_frame(16'h0942, 4'b0000, 1'b0);
    check_frame("freeze_a");
    push_frame(16'h0942, 4'b0000, 1'b0);
    check_frame("freeze_b");

    // Request exactly in the boundary tick cycle.
    acks = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      acks += int'(SNAP_ACK);
      SNAP_REQ  = (i == 15);
      DIGITS_IN = (i == 15) ? 16'h0311 : 16'h0777;
    end
    chk("coin_ack_at_frame", {14'd0, SNAP_ACK, FRAME}, 16'h0003);
    chk("coin_ack_count", 16'(acks), 16'd1);
    SNAP_REQ = 1'b0;
    push_frame(16'h0942, 4'b0000, 1'b0);
    check_frame("coin_old_snap");
    push_frame(16'h0311, 4'b0000, 1'b0);
    check_frame("coin_new_snap");

    // Leading-zero blanking, decimal point, invalid digit.
    FREEZE = 1'b0; BLANK_LZ = 1'b1; DP_MASK = 4'b0100;
    DIGITS_IN = 16'h0007;
    push_frame(16'h0311, 4'b0100, 1'b1);
    check_frame("blank0311");
    DIGITS_IN = 16'h00A0;
    push_frame(16'h0007, 4'b0100, 1'b1);
    check_frame("blank0007");
    push_frame(16'h00A0, 4'b0100, 1'b1);
    check_frame("dash00A0");

    // Reset mid-handshake: request is lost and outputs clear without a clock.
    BLANK_LZ = 1'b0; DP_MASK = 4'b0000;
    DIGITS_IN = 16'h0959;
    SNAP_REQ = 1'b1;
    @(negedge CLK);
    SNAP_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_an",  {12'd0, AN}, 16'h000F);
    chk("async_rst_seg", {9'd0, SEG}, 16'h007F);
    chk("async_rst_dp",  {15'd0, DP}, 16'd1);
    chk("async_rst_ack", {14'd0, SNAP_ACK, FRAME}, 16'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    FREEZE = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      acks += int'(SNAP_ACK);
    end
    chk("rst_lost_ack_count", 16'(acks), 16'd0);
    wait_frame("rst_snap");
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame("rst_snap_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
Reader and presenter for the stopwatch's BCD time counters, built from the team's flip-flop counter stages. It time-multiplexes four BCD digits onto a common 7-segment display. Digit values change only at frame boundaries, so the display never tears. A snapshot/lap handshake lets the control logic freeze a displayed time while the counters keep running.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot; minimum 2.
BLANK_EN, 1, when 1 enables leading-zero blanking via the BLANK_LZ input; when 0, BLANK_LZ is ignored.

Ports:
CLK  input  1  system clock; all state is clocked on its rising edge.
RST  input  1  asynchronous, active-low reset.
DIGITS_IN  input  16  live BCD time; [15:12] is the most significant digit (digit 3), [3:0] is digit 0.
DP_MASK  input  4  decimal-point enable per digit, with bit i for digit i; 1 lights the point.
FREEZE  input  1  level; when 1 the display shows the snapshot register, when 0 it shows live digits.
SNAP_REQ  input  1  pulse; requests that DIGITS_IN be captured into the snapshot register.
BLANK_LZ  input  1  level; enables leading-zero blanking.
SNAP_ACK  output  1  one-cycle pulse confirming that the snapshot was captured.
FRAME  output  1  one-cycle pulse at each frame boundary.
AN  output  4  digit select, active-low, one-hot.
SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
DP  output  1  decimal point, active-low.

Behaviour:
- Reset (RST=0, asynchronous). The following are cleared:
  - prescaler=0, index=0, DISP=16'h0000, SNAP=16'h0000, pending=0;
  - AN=4'b1111, SEG=7'b1111111, DP=1, SNAP_ACK=0, FRAME=0.
  - Asserting reset mid-frame or mid-handshake aborts immediately; a pending request is lost.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick is high in the cycle where the count equals CLK_DIV-1.
- Digit index:
  - A 2-bit index advances on tick as 0→1→2→3→0.
  - A frame boundary is a tick while index==3.
- At a frame boundary, the display register DISP loads SNAP if FREEZE=1, else DIGITS_IN. At no other time does DISP change.
- FRAME is registered and is high for the one cycle after a boundary tick.
- Snapshot handshake:
  - SNAP_REQ=1 in any cycle sets pending.
  - At the first boundary with pending=1, SNAP loads DIGITS_IN, pending clears, and SNAP_ACK pulses for the one cycle after the boundary, coincident with FRAME.
  - A SNAP_REQ in the boundary cycle itself is captured at that same boundary.
  - Further requests while pending is set merge into the one pending request and yield one ACK.
  - When SNAP and DISP load at the same boundary with FREEZE=1, DISP gets the old SNAP value. The new snapshot appears one frame later.
- Output stage (registered, one-cycle latency after an index change):
  - AN has a 0 at the bit equal to index; all other bits are 1.
  - DP = ~DP_MASK[index].
  - SEG is the decode of DISP digit [index].
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 show a dash: 0111111.
- Blanking (BLANK_EN=1 and BLANK_LZ=1):
  - Digit 3 is blanked (SEG=1111111) when it is 0.
  - Digit 2 is blanked when digits 3 and 2 are both 0.
  - Digits 1 and 0 are never blanked.
  - DP follows DP_MASK even on a blanked digit.
- The first tick after reset advances index to 1. Before that tick, the output shows digit 0 of DISP=0: AN=1110, SEG=1000000. The reset values of AN/SEG/DP hold only for the cycle(s) while RST is low.

Test Plan:
- Reset and scan, CLK_DIV=4, DIGITS_IN=16'h1234, FREEZE=0:
  - after the first boundary, AN cycles 1110,1101,1011,0111 every 4 cycles;
  - SEG shows 4,3,2,1 = 0011001,0110000,0100100,1111001;
  - FRAME pulses every 16 cycles.
- Tear-free update: change DIGITS_IN to 16'h5678 mid-frame → SEG keeps showing 1234 digits until the next FRAME, then 8,7,6,5.
- Snapshot and freeze:
  - DIGITS_IN=16'h0942, pulse SNAP_REQ twice within one frame → exactly one SNAP_ACK, coincident with FRAME.
  - Set FREEZE=1 and change DIGITS_IN to 16'h0959 → display stays at 0942 from the following frame onward.
- Boundary coincidence: SNAP_REQ asserted exactly in a boundary tick cycle → SNAP_ACK on the very next cycle with SNAP = DIGITS_IN sampled at that tick.
- Blanking and invalid digit:
  - BLANK_LZ=1 with DISP=16'h0007 → digits 3 and 2 show 1111111, digit 1 shows 1000000, digit 0 shows 1111000.
  - DISP=16'h00A0 → digit 1 shows 0111111.
  - DP_MASK=4'b0100 → DP=0 only while AN=1011.
- Reset mid-handshake: SNAP_REQ, then RST low before the boundary → no SNAP_ACK, SNAP=0; all outputs reset on RST falling without waiting for CLK.
